sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Multi-port front-end for one single-port synchronous SRAM macro (SramWrap class).
//  Arbitrates NUM_PORTS requesters (ifetch, load/store, debug/DMA, ...) onto one memory port.
//  Round-robin grant with optional per-port lock for atomic read-modify-write sequences.
//  Read data is routed back to the issuing port. Sits between the core memory interfaces and the data SRAM.
// PARAMETERS
//  NUM_PORTS  2   number of requesters, 2..8
//  ADDR_W     12  word address width, equals SRAM ADRESS_WIDTH
//  DATA_W     32  data width; must be a multiple of 8
//  MASK_W     DATA_W/8  byte write-enable width
//  PID_W      $clog2(NUM_PORTS)  port-id width, derived; do not override
// PORTS
//  clk        in   1                 single clock; SRAM shares it
//  rst_n      in   1                 asynchronous active-low reset
//  req        in   NUM_PORTS         per-port request
//  lock       in   NUM_PORTS         per-port hold-grant request; sampled only with req
//  wen        in   NUM_PORTS         per-port write (1) / read (0)
//  addr       in   NUM_PORTS*ADDR_W  per-port word address
//  wdata      in   NUM_PORTS*DATA_W  per-port write data
//  wmask      in   NUM_PORTS*MASK_W  per-port byte write mask
//  gnt        out  NUM_PORTS         one-hot grant; request accepted this cycle
//  rsp_valid  out  NUM_PORTS         one-hot; read data valid for that port
//  rsp_data   out  DATA_W            read data, shared bus; qualified by rsp_valid
//  mem_cen    out  1                 SRAM chip enable, active high
//  mem_wen    out  1                 SRAM write enable
//  mem_addr   out  ADDR_W            SRAM address
//  mem_din    out  DATA_W            SRAM write data
//  mem_mask   out  MASK_W            SRAM byte mask
//  mem_dout   in   DATA_W            SRAM read data; valid 1 cycle after enabled read
// BEHAVIOUR
//  Reset values: rr_ptr=0, lock_own=0, lock_pid=0, rsp_valid=0, rsp_pid=0, gnt=0, mem_cen=0.
//  gnt and mem_* are combinational from req, rr_ptr and lock state. No request-side buffering.
//  Arbitration:
//   - Scan ports starting at rr_ptr and wrapping modulo NUM_PORTS; the first port with req=1 wins.
//   - On any grant, rr_ptr <= winner+1, wrapping from NUM_PORTS-1 to 0.
//  Lock state machine, states IDLE/LOCKED:
//   - IDLE->LOCKED when the granted port has lock=1; lock_pid <= winner.
//   - In LOCKED, only lock_pid may be granted; other ports see gnt=0, even if lock_pid is idle.
//   - LOCKED->IDLE when lock_pid has req=1 and lock=0 (that request is still granted),
//     or when lock_pid has req=0 and lock=0.
//   - rr_ptr does not advance while LOCKED.
//  Handshake:
//   - A transfer occurs in a cycle where req[i]&gnt[i]=1.
//   - The requester holds addr/wen/wdata/wmask stable until granted.
//   - Dropping req before grant is legal and has no effect.
//  Memory drive: mem_cen=|gnt; mem_* carry the winner's fields. mem_* are zero when mem_cen=0.
//  Read latency is 1 cycle:
//   - A read granted in cycle N gives rsp_valid[pid]=1 and rsp_data=mem_dout in cycle N+1.
//   - Back-to-back reads from any ports give one response per cycle, in grant order.
//  Writes produce no rsp_valid. mem_mask applies bytewise; wmask=0 is a legal no-op write.
//  There is no response backpressure: the requester must accept rsp_valid when it arrives.
//  rsp_data is 0 when rsp_valid=0.
//  Same address read+write by different ports in the same cycle: only one is granted.
//   A read granted after a write returns the new data.
//  Reset mid-operation: a pending response is discarded (rsp_valid=0) and the lock is released.
// CONFIGURATION
//  SRAM_ARB_PERF_EN defined:
//   - Adds outputs perf_grants[NUM_PORTS*32] and perf_stalls[NUM_PORTS*32].
//   - perf_grants[i] increments on each grant to i; perf_stalls[i] on each cycle req[i]&!gnt[i].
//   - Counters saturate at 2^32-1, reset to 0, and are cleared by input perf_clr (1 bit, synchronous).
//  SRAM_ARB_PERF_EN undefined: perf_* ports and counters are absent, with no other change.
// STRUCTURE
//  Package sram_arb_pkg holds:
//   - typedef mem_req_t {wen, addr, wdata, wmask}
//   - typedef lock_state_e {IDLE, LOCKED}
//   - localparams for default ADDR_W=12 and DATA_W=32
//  Sub-module rr_picker(NUM_PORTS): combinational req+ptr -> one-hot winner plus winner id.
//  The lock FSM, response pipeline and perf counters stay in sram_port_arbiter.
// TESTING
//  Ports 0..2 req every cycle, all reads -> gnt order 0,1,2,0,1,2; rsp_valid follows each by 1 cycle.
//  Port1 writes 0xDEADBEEF with mask 4'b0101 to addr 0x010 over initial 0 -> later read gives 0x00AD00EF.
//  Port0 lock=1 for 3 reqs while port1 reqs -> port1 gnt=0 until port0 req with lock=0, then port1 granted next.
//  Only port 2 reqs while rr_ptr=0 -> granted the same cycle; rr_ptr becomes 0 (wraps from 3, NUM_PORTS=3).
//  Read granted, rst_n low the next cycle -> rsp_valid stays 0 and lock released; first post-reset grant goes to port 0.
//  SRAM_ARB_PERF_EN on: port1 stalled 4 cycles then granted -> perf_stalls[1]=4, perf_grants[1]=1; perf_clr zeroes both.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM port arbiter.
// Holds the lock FSM state type, the default memory geometry, a memory request
// record at that default geometry, and the modulo index helper used by the picker.
package sram_arb_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_MASK_W = DEF_DATA_W / 8;

  typedef enum logic {
    IDLE,
    LOCKED
  } lock_state_e;

  typedef struct packed {
    logic                  wen;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
    logic [DEF_MASK_W-1:0] wmask;
  } mem_req_t;

  // Port index reached by stepping 'offset' places from 'base' in a ring of n ports.
  function automatic int wrapIdx(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_picker.sv
// Round-robin picker: scans the request vector starting at ptr, wrapping around,
// and reports the first requesting port as a one-hot vector plus its index.
// Purely combinational; the pointer itself lives in the arbiter.
module rr_picker
  import sram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int PID_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PID_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] winner,
  output logic [PID_W-1:0]     winnerId,
  output logic                 found
);

  logic [PID_W-1:0] idx;

  // First requester at or after ptr (modulo NUM_PORTS) wins; later ones are masked off.
  always_comb begin
    winner   = '0;
    winnerId = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = PID_W'(wrapIdx(int'(ptr), i, NUM_PORTS));
      if (!found && req[idx]) begin
        found       = 1'b1;
        winner[idx] = 1'b1;
        winnerId    = idx;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Multi-port front-end for a single-port synchronous SRAM.
// Round-robin arbitration with a per-port lock for atomic read-modify-write,
// and a one-cycle read response routed back to the issuing port.
// Optional feature macro: SRAM_ARB_PERF_EN adds per-port grant/stall counters
// (perf_clr, perf_grants, perf_stalls); without it those ports do not exist.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MASK_W    = DATA_W / 8,
  parameter int PID_W     = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        lock,
  input  logic [NUM_PORTS-1:0]        wen,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  input  logic [NUM_PORTS*MASK_W-1:0] wmask,
  output logic [NUM_PORTS-1:0]        gnt,
  output logic [NUM_PORTS-1:0]        rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        mem_cen,
  output logic                        mem_wen,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_din,
  output logic [MASK_W-1:0]           mem_mask,
  input  logic [DATA_W-1:0]           mem_dout
`ifdef SRAM_ARB_PERF_EN
  ,
  input  logic                        perf_clr,
  output logic [NUM_PORTS*32-1:0]     perf_grants,
  output logic [NUM_PORTS*32-1:0]     perf_stalls
`endif
);

  lock_state_e          lockState;
  logic [PID_W-1:0]     lockPid;
  logic [PID_W-1:0]     rrPtr;
  logic                 lockOwn;

  logic [NUM_PORTS-1:0] pickWinner;
  logic [PID_W-1:0]     pickId;
  logic                 pickFound;

  logic [PID_W-1:0]     gntPid;
  logic                 granted;

  logic                 rspActive;
  logic [PID_W-1:0]     rspPid;

  assign lockOwn = (lockState == LOCKED);

  rr_picker #(
    .NUM_PORTS(NUM_PORTS),
    .PID_W    (PID_W)
  ) uPicker (
    .req     (req),
    .ptr     (rrPtr),
    .winner  (pickWinner),
    .winnerId(pickId),
    .found   (pickFound)
  );

  // While locked only the owner can be granted, and only when it actually requests.
  always_comb begin
    gnt    = '0;
    gntPid = '0;
    if (lockOwn) begin
      gnt[lockPid] = req[lockPid];
      gntPid       = lockPid;
    end else begin
      gnt    = pickWinner;
      gntPid = pickId;
    end
  end

  assign granted = |gnt;

  // Memory port carries the winner's request fields and is held at zero when idle.
  always_comb begin
    mem_cen  = 1'b0;
    mem_wen  = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    mem_mask = '0;
    if (granted) begin
      mem_cen  = 1'b1;
      mem_wen  = wen[gntPid];
      mem_addr = addr[int'(gntPid)*ADDR_W +: ADDR_W];
      mem_din  = wdata[int'(gntPid)*DATA_W +: DATA_W];
      mem_mask = wmask[int'(gntPid)*MASK_W +: MASK_W];
    end
  end

  // Lock FSM plus round-robin pointer; the pointer is frozen for the whole locked span.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lockState <= IDLE;
      lockPid   <= '0;
      rrPtr     <= '0;
    end else begin
      case (lockState)
        IDLE: begin
          if (pickFound) begin
            rrPtr <= PID_W'(wrapIdx(int'(pickId), 1, NUM_PORTS));
            if (lock[pickId]) begin
              lockState <= LOCKED;
              lockPid   <= pickId;
            end
          end
        end
        LOCKED: begin
          if (!lock[lockPid]) begin
            lockState <= IDLE;
          end
        end
        default: lockState <= IDLE;
      endcase
    end
  end

  // Remember which port issued a read so its data can be steered back next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rspActive <= 1'b0;
      rspPid    <= '0;
    end else begin
      rspActive <= granted && !mem_wen;
      if (granted && !mem_wen) begin
        rspPid <= gntPid;
      end
    end
  end

  assign rsp_valid = rspActive ? (NUM_PORTS'(1) << rspPid) : '0;
  assign rsp_data  = rspActive ? mem_dout : '0;

`ifdef SRAM_ARB_PERF_EN
  logic [31:0] grantCnt [NUM_PORTS];
  logic [31:0] stallCnt [NUM_PORTS];

  // Saturating per-port grant and stall counters with a synchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        grantCnt[i] <= '0;
        stallCnt[i] <= '0;
      end
    end else if (perf_clr) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        grantCnt[i] <= '0;
        stallCnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (gnt[i] && (grantCnt[i] != '1)) begin
          grantCnt[i] <= grantCnt[i] + 32'd1;
        end
        if (req[i] && !gnt[i] && (stallCnt[i] != '1)) begin
          stallCnt[i] <= stallCnt[i] + 32'd1;
        end
      end
    end
  end

  // Flatten the counter arrays onto the output buses, port 0 in the low word.
  always_comb begin
    perf_grants = '0;
    perf_stalls = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      perf_grants[i*32 +: 32] = grantCnt[i];
      perf_stalls[i*32 +: 32] = stallCnt[i];
    end
  end
`else
  // Default build: no performance counters.
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter with three ports.
// Table-driven per-cycle vectors carry the expected grant; a shadow memory and a
// response queue predict read data. Reset mid-operation and the perf counters
// (SRAM_ARB_PERF_EN builds only) are exercised as hand-written sequences.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam int NP = 3;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MW = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NP-1:0]    req, lock, wen;
  logic [NP*AW-1:0] addr;
  logic [NP*DW-1:0] wdata;
  logic [NP*MW-1:0] wmask;
  logic [NP-1:0]    gnt, rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic             mem_cen, mem_wen;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_din;
  logic [MW-1:0]    mem_mask;
  logic [DW-1:0]    mem_dout;
`ifdef SRAM_ARB_PERF_EN
  logic             perf_clr;
  logic [NP*32-1:0] perf_grants, perf_stalls;
`endif

  typedef struct {
    string         name;
    logic [NP-1:0] req, lock, wen;
    logic [AW-1:0] a0, a1, a2;
    logic [DW-1:0] wd;
    logic [MW-1:0] wm;
    logic [NP-1:0] expGnt;
  } vec_t;

  typedef struct {
    int            pid;
    logic [DW-1:0] data;
  } rsp_t;

  vec_t          vecs[$];
  rsp_t          sb[$];
  logic [DW-1:0] sramArr [0:(1<<AW)-1];
  logic [DW-1:0] expMem  [0:(1<<AW)-1];
  int            checks = 0;
  int            fails  = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .NUM_PORTS(NP),
    .ADDR_W   (AW),
    .DATA_W   (DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .lock     (lock),
    .wen      (wen),
    .addr     (addr),
    .wdata    (wdata),
    .wmask    (wmask),
    .gnt      (gnt),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .mem_cen  (mem_cen),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_mask (mem_mask),
    .mem_dout (mem_dout)
`ifdef SRAM_ARB_PERF_EN
    ,
    .perf_clr   (perf_clr),
    .perf_grants(perf_grants),
    .perf_stalls(perf_stalls)
`endif
  );

  // Behavioural single-port SRAM: bytewise masked write, one-cycle read.
  always @(posedge clk) begin
    if (mem_cen) begin
      if (mem_wen) begin
        for (int b = 0; b < MW; b++)
          if (mem_mask[b]) sramArr[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
      end else begin
        mem_dout <= sramArr[mem_addr];
      end
    end
  end

  function automatic vec_t mkVec(input string nm, input logic [NP-1:0] rq, input logic [NP-1:0] lk,
                                 input logic [NP-1:0] we, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                 input logic [AW-1:0] a2, input logic [DW-1:0] wd, input logic [MW-1:0] wm,
                                 input logic [NP-1:0] eg);
    vec_t v;
    v.name = nm; v.req = rq; v.lock = lk; v.wen = we;
    v.a0 = a0; v.a1 = a1; v.a2 = a2; v.wd = wd; v.wm = wm; v.expGnt = eg;
    return v;
  endfunction

  task automatic checkVal(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic checkOutput(input string nm);
    rsp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkVal({nm, " rsp_valid"}, 64'(rsp_valid), 64'(1) << e.pid);
      checkVal({nm, " rsp_data"}, 64'(rsp_data), 64'(e.data));
    end else begin
      checkVal({nm, " rsp_valid idle"}, 64'(rsp_valid), 64'd0);
      checkVal({nm, " rsp_data idle"}, 64'(rsp_data), 64'd0);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int            pid;
    logic [AW-1:0] a;
    mem_req_t      expReq, actReq;
    @(negedge clk);
    req   = v.req;
    lock  = v.lock;
    wen   = v.wen;
    addr  = {v.a2, v.a1, v.a0};
    wdata = {NP{v.wd}};
    wmask = {NP{v.wm}};
    #1;
    checkVal({v.name, " gnt"}, 64'(gnt), 64'(v.expGnt));
    pid = -1;
    for (int i = 0; i < NP; i++) if (v.expGnt[i]) pid = i;
    actReq = '{wen: mem_wen, addr: mem_addr, wdata: mem_din, wmask: mem_mask};
    if (pid < 0) begin
      checkVal({v.name, " mem_cen"}, 64'(mem_cen), 64'd0);
      checkVal({v.name, " mem idle"}, 64'(actReq), 64'd0);
    end else begin
      a = (pid == 0) ? v.a0 : (pid == 1) ? v.a1 : v.a2;
      expReq = '{wen: v.wen[pid], addr: a, wdata: v.wd, wmask: v.wm};
      checkVal({v.name, " mem_cen"}, 64'(mem_cen), 64'd1);
      checkVal({v.name, " mem req"}, 64'(actReq), 64'(expReq));
      if (v.wen[pid]) begin
        for (int b = 0; b < MW; b++)
          if (v.wm[b]) expMem[a][b*8 +: 8] = v.wd[b*8 +: 8];
      end else begin
        sb.push_back('{pid: pid, data: expMem[a]});
      end
    end
    @(posedge clk);
    #1;
    checkOutput(v.name);
  endtask

  initial begin
    // Stimulus table: req, lock, wen, addr0..2, wdata, wmask, expected grant.
    vecs.push_back(mkVec("p1 masked wr", 3'b010, 3'b000, 3'b010, 12'h000, 12'h010, 12'h000, 32'hDEADBEEF, 4'b0101, 3'b010));
    vecs.push_back(mkVec("p0 wr",        3'b001, 3'b000, 3'b001, 12'h030, 12'h000, 12'h000, 32'hCAFEF00D, 4'b1111, 3'b001));
    vecs.push_back(mkVec("p2 wr",        3'b100, 3'b000, 3'b100, 12'h000, 12'h000, 12'h020, 32'h12345678, 4'b1111, 3'b100));
    for (int k = 0; k < 6; k++)
      vecs.push_back(mkVec("rr rd", 3'b111, 3'b000, 3'b000, 12'h030, 12'h010, 12'h020, 32'h0, 4'h0,
                           3'(1 << (k % 3))));
    vecs.push_back(mkVec("zero-mask wr", 3'b010, 3'b000, 3'b010, 12'h000, 12'h010, 12'h000, 32'hFFFFFFFF, 4'b0000, 3'b010));
    vecs.push_back(mkVec("rd after noop",3'b010, 3'b000, 3'b000, 12'h000, 12'h010, 12'h000, 32'h0, 4'h0, 3'b010));
    vecs.push_back(mkVec("idle",         3'b000, 3'b000, 3'b000, 12'h000, 12'h000, 12'h000, 32'h0, 4'h0, 3'b000));
    vecs.push_back(mkVec("race rd wins", 3'b101, 3'b000, 3'b001, 12'h040, 12'h000, 12'h040, 32'hA5A5A5A5, 4'b1111, 3'b100));
    vecs.push_back(mkVec("race held wr", 3'b001, 3'b000, 3'b001, 12'h040, 12'h000, 12'h040, 32'hA5A5A5A5, 4'b1111, 3'b001));
    vecs.push_back(mkVec("rd new data",  3'b100, 3'b000, 3'b000, 12'h040, 12'h000, 12'h040, 32'h0, 4'h0, 3'b100));
    vecs.push_back(mkVec("p2 at ptr0",   3'b100, 3'b000, 3'b000, 12'h030, 12'h010, 12'h020, 32'h0, 4'h0, 3'b100));
    vecs.push_back(mkVec("ptr wrapped",  3'b111, 3'b000, 3'b000, 12'h030, 12'h010, 12'h020, 32'h0, 4'h0, 3'b001));
    vecs.push_back(mkVec("lock take",    3'b001, 3'b001, 3'b000, 12'h030, 12'h010, 12'h020, 32'h0, 4'h0, 3'b001));
    vecs.push_back(mkVec("lock hold1",   3'b011, 3'b001, 3'b000, 12'h030, 12'h010, 12'h020, 32'h0, 4'h0, 3'b001));
    vecs.push_back(mkVec("lock hold2",   3'b011, 3'b001, 3'b000, 12'h030, 12'h010, 12'h020, 32'h0, 4'h0, 3'b001));
    vecs.push_back(mkVec("owner idle",   3'b010, 3'b001, 3'b000, 12'h030, 12'h010, 12'h020, 32'h0, 4'h0, 3'b000));
    vecs.push_back(mkVec("lock release", 3'b011, 3'b000, 3'b000, 12'h030, 12'h010, 12'h020, 32'h0, 4'h0, 3'b001));
    vecs.push_back(mkVec("after release",3'b011, 3'b000, 3'b000, 12'h030, 12'h010, 12'h020, 32'h0, 4'h0, 3'b010));
    vecs.push_back(mkVec("p2 lock",      3'b100, 3'b100, 3'b000, 12'h030, 12'h010, 12'h020, 32'h0, 4'h0, 3'b100));
    vecs.push_back(mkVec("drop lock",    3'b001, 3'b000, 3'b000, 12'h030, 12'h010, 12'h020, 32'h0, 4'h0, 3'b000));
    vecs.push_back(mkVec("unlocked",     3'b001, 3'b000, 3'b000, 12'h030, 12'h010, 12'h020, 32'h0, 4'h0, 3'b001));

    for (int i = 0; i < (1 << AW); i++) begin
      sramArr[i] = '0;
      expMem[i]  = '0;
    end
    mem_dout = '0;
    rst_n = 1'b0;
    req = '0; lock = '0; wen = '0; addr = '0; wdata = '0; wmask = '0;
`ifdef SRAM_ARB_PERF_EN
    perf_clr = 1'b0;
`endif

    repeat (2) @(posedge clk);
    #1;
    checkVal("reset gnt", 64'(gnt), 64'd0);
    checkVal("reset mem_cen", 64'(mem_cen), 64'd0);
    checkVal("reset rsp_valid", 64'(rsp_valid), 64'd0);
    checkVal("reset rsp_data", 64'(rsp_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Read granted with lock, then reset lands right after the grant edge.
    @(negedge clk);
    req = 3'b010; lock = 3'b010; wen = 3'b000; addr = {12'h020, 12'h010, 12'h030};
    #1;
    checkVal("rstmid gnt", 64'(gnt), 64'b010);
    @(posedge clk);
    #1;
    checkVal("rstmid rsp before rst", 64'(rsp_valid), 64'b010);
    rst_n = 1'b0;
    req = '0; lock = '0;
    #1;
    checkVal("rstmid rsp_valid", 64'(rsp_valid), 64'd0);
    checkVal("rstmid rsp_data", 64'(rsp_data), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(mkVec("post-reset", 3'b111, 3'b000, 3'b000, 12'h030, 12'h010, 12'h020, 32'h0, 4'h0, 3'b001));

`ifdef SRAM_ARB_PERF_EN
    @(negedge clk);
    req = '0; lock = '0; perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    applyStimulus(mkVec("perf lock",  3'b001, 3'b001, 3'b000, 12'h030, 12'h010, 12'h020, 32'h0, 4'h0, 3'b001));
    for (int k = 0; k < 3; k++)
      applyStimulus(mkVec("perf hold", 3'b011, 3'b001, 3'b000, 12'h030, 12'h010, 12'h020, 32'h0, 4'h0, 3'b001));
    applyStimulus(mkVec("perf rel",   3'b011, 3'b000, 3'b000, 12'h030, 12'h010, 12'h020, 32'h0, 4'h0, 3'b001));
    applyStimulus(mkVec("perf p1",    3'b010, 3'b000, 3'b000, 12'h030, 12'h010, 12'h020, 32'h0, 4'h0, 3'b010));
    checkVal("perf_stalls[1]", 64'(perf_stalls[32 +: 32]), 64'd4);
    checkVal("perf_grants[1]", 64'(perf_grants[32 +: 32]), 64'd1);
    checkVal("perf_grants[0]", 64'(perf_grants[0 +: 32]), 64'd5);
    @(negedge clk);
    req = '0; perf_clr = 1'b1;
    @(posedge clk);
    #1;
    perf_clr = 1'b0;
    checkVal("perf clr stalls", 64'(perf_stalls), 64'd0);
    checkVal("perf clr grants", 64'(perf_grants), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
